// File: rtl/sim_run_watchdog.sv
// rtl/sim_run_watchdog.sv - run controller and watchdog for simulation tops
//
// Sequences a test run through IDLE -> RUN -> DRAIN -> DONE. Enforces a global
// cycle timeout and per-channel idle (stall) detection, and issues a
// finish request with a pass/fail verdict.
//
// Ports:
//   clk        free-running clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (sampled in IDLE or DONE)
//   stop       test-complete request (sampled in RUN)
//   activity   per-channel activity strobe
//   ch_en      per-channel monitor enable
//   state      0=IDLE 1=RUN 2=DRAIN 3=DONE
//   cycle_cnt  cycles elapsed since entering RUN
//   stall_ch   sticky per-channel stall flags
//   timeout    sticky global timeout flag
//   finish_req high while in DONE
//   pass       verdict, valid while finish_req=1
module sim_run_watchdog #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 12500,
    parameter int IDLE_LIMIT   = 1000,
    parameter int IDLE_W       = 16,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] activity,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [NUM_CH-1:0] stall_ch,
    output logic              timeout,
    output logic              finish_req,
    output logic              pass
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CH-1:0]  stall_q, stall_d;
    logic               timeout_q, timeout_d;
    logic               finish_q, finish_d;
    logic               pass_q, pass_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q [NUM_CH];
    logic [IDLE_W-1:0]  idle_cnt_d [NUM_CH];

    logic               monitoring;
    logic               entering_run;
    logic               cnt_at_max;
    logic               drain_last;
    logic [NUM_CH-1:0]  new_stall;

    assign monitoring   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign entering_run = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign cnt_at_max   = (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));
    // Only meaningful in DRAIN, which is unreachable when DRAIN_CYCLES=0.
    assign drain_last   = (int'(drain_cnt_q) == DRAIN_CYCLES - 1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            stall_q     <= '0;
            timeout_q   <= 1'b0;
            finish_q    <= 1'b0;
            pass_q      <= 1'b0;
            drain_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                idle_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_q     <= stall_d;
            timeout_q   <= timeout_d;
            finish_q    <= finish_d;
            pass_q      <= pass_d;
            drain_cnt_q <= drain_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                idle_cnt_q[i] <= idle_cnt_d[i];
            end
        end
    end

    // Per-channel idle monitoring. A stall is flagged from the registered
    // count, so the flag appears the cycle after the count shows IDLE_LIMIT.
    always_comb begin
        new_stall = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idle_cnt_d[i] = idle_cnt_q[i];
            if (!monitoring || activity[i] || !ch_en[i]) begin
                idle_cnt_d[i] = '0;
            end else if (idle_cnt_q[i] != IDLE_W'(IDLE_LIMIT)) begin
                idle_cnt_d[i] = idle_cnt_q[i] + IDLE_W'(1);
            end
            new_stall[i] = monitoring && ch_en[i] && !stall_q[i] &&
                           (idle_cnt_q[i] == IDLE_W'(IDLE_LIMIT));
        end
    end

    // Next-state logic: timeout beats stall, stall beats stop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_at_max)      state_d = S_DONE;
                else if (|new_stall) state_d = S_DONE;
                else if (stop)       state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                // New stalls during drain only set flags; they do not end it early.
                if (cnt_at_max || drain_last) state_d = S_DONE;
            end
            default: begin
                if (start) state_d = S_RUN;
            end
        endcase
    end

    // Counters, flags and registered outputs
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_d     = stall_q;
        timeout_d   = timeout_q;
        drain_cnt_d = '0;

        if (entering_run) begin
            cycle_cnt_d = '0;
            stall_d     = '0;
            timeout_d   = 1'b0;
        end else if (monitoring) begin
            if (cycle_cnt_q != {CNT_W{1'b1}}) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
            stall_d = stall_q | new_stall;
            if (cnt_at_max) timeout_d = 1'b1;
        end else if (state_q == S_IDLE) begin
            cycle_cnt_d = '0;
        end

        if (state_q == S_DRAIN) begin
            drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end

        finish_d = (state_d == S_DONE);
        pass_d   = (state_d == S_DONE) && !timeout_d && (stall_d == '0);
    end

    assign state      = state_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign stall_ch   = stall_q;
    assign timeout    = timeout_q;
    assign finish_req = finish_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_sim_run_watchdog.sv
// tb/tb_sim_run_watchdog.sv - scoreboard testbench for sim_run_watchdog
module tb_sim_run_watchdog;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [NUM_CH-1:0] activity;
    logic [NUM_CH-1:0] ch_en;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [NUM_CH-1:0] stall_ch;
    logic              timeout;
    logic              finish_req;
    logic              pass;

    sim_run_watchdog #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAX_CYCLES(100),
        .IDLE_LIMIT(10), .IDLE_W(16), .DRAIN_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .activity(activity), .ch_en(ch_en), .state(state),
        .cycle_cnt(cycle_cnt), .stall_ch(stall_ch), .timeout(timeout),
        .finish_req(finish_req), .pass(pass)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic        to;
        logic        ps;
        logic [1:0]  st;
        logic [31:0] cyc;
        bit          chk_cyc;
        int          drain;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic to, input logic ps, input logic [1:0] st,
                        input logic [31:0] cyc, input bit chk_cyc, input int drain);
        exp_t x;
        x.to = to; x.ps = ps; x.st = st; x.cyc = cyc; x.chk_cyc = chk_cyc; x.drain = drain;
        sb.push_back(x);
    endtask

    // Monitor: on every rising finish_req pop an expected verdict and compare.
    logic [1:0] prev_state = 2'd0;
    logic       prev_fin   = 1'b0;
    int         drain_seen = 0;
    always @(negedge clk) begin
        if (state == 2'd1 && prev_state != 2'd1) drain_seen = 0;
        if (state == 2'd2) drain_seen++;
        if (finish_req && !prev_fin) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_state", 32'(state), 3);
                check("timeout", 32'(timeout), 32'(e.to));
                check("pass", 32'(pass), 32'(e.ps));
                check("stall_ch", 32'(stall_ch), 32'(e.st));
                check("drain_cycles", drain_seen, e.drain);
                if (e.chk_cyc) check("cycle_cnt", cycle_cnt, e.cyc);
            end
        end
        prev_state = state;
        prev_fin   = finish_req;
    end

    // mode 0: toggle both, 1: both busy, 2: only ch0 active,
    // 3: both busy until cycle 89 then only ch0 active
    task automatic drive(input int mode, input int stop_at, input logic [1:0] en);
        bit ok;
        ch_en = en;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (finish_req) begin
                ok = 1;
                break;
            end
            case (mode)
                0:       activity = {2{cycle_cnt[0]}};
                1:       activity = 2'b11;
                2:       activity = 2'b01;
                default: activity = (cycle_cnt < 89) ? 2'b11 : 2'b01;
            endcase
            stop = (state == 2'd1) && (stop_at >= 0) && (int'(cycle_cnt) == stop_at);
            @(posedge clk); #1;
        end
        stop     = 1'b0;
        activity = 2'b00;
        if (!ok) check("done_within_bound", 0, 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; activity = 2'b00; ch_en = 2'b11;
        #20;
        check("rst_state", 32'(state), 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_stall", 32'(stall_ch), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_finish", 32'(finish_req), 0);
        check("rst_pass", 32'(pass), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Clean run: stop at 20, drain 21..24, DONE at 25
        push(1'b0, 1'b1, 2'b00, 25, 1, 4);
        drive(0, 20, 2'b11);

        // Global timeout, never stop
        push(1'b1, 1'b0, 2'b00, 0, 0, 0);
        drive(1, -1, 2'b11);

        // ch1 idle from the start: count hits 10 at cycle 10, DONE at 11
        push(1'b0, 1'b0, 2'b10, 11, 1, 0);
        drive(2, -1, 2'b11);

        // Timeout, new stall and stop all in cycle 99
        push(1'b1, 1'b0, 2'b10, 0, 0, 0);
        drive(3, 99, 2'b11);

        // Restart from DONE
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart_state", 32'(state), 1);
        check("restart_cycle_cnt", cycle_cnt, 0);
        check("restart_stall", 32'(stall_ch), 0);
        check("restart_timeout", 32'(timeout), 0);
        check("restart_finish", 32'(finish_req), 0);
        check("restart_pass", 32'(pass), 0);

        // Asynchronous reset mid-RUN
        activity = 2'b11;
        repeat (5) @(posedge clk);
        #2;
        check("pre_reset_cycle_cnt", cycle_cnt, 5);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_cycle_cnt", cycle_cnt, 0);
        check("async_rst_finish", 32'(finish_req), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        activity = 2'b00;

        // Disabled idle channel never stalls
        push(1'b0, 1'b1, 2'b00, 55, 1, 4);
        drive(2, 50, 2'b01);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_run_watchdog.md
Name: sim_run_watchdog

Overview:
Parametrised, clocked run controller and watchdog for simulation tops. It replaces a hard-coded fixed-delay finish with a cycle-accurate global timeout, per-channel activity monitoring, a drain phase after test completion, and a pass/fail verdict. It is instantiated in the testbench top next to the DUT. Its finish_req output is what calls $finish.

Parameters:
NUM_CH, 4, number of monitored activity channels (1..32)
CNT_W, 32, width of the global cycle counter
MAX_CYCLES, 12500, global timeout in clk cycles (100 us at an 8 ns clock period)
IDLE_LIMIT, 1000, consecutive inactive cycles on an enabled channel before it is flagged stalled
IDLE_W, 16, width of each per-channel idle counter; IDLE_LIMIT < 2**IDLE_W
DRAIN_CYCLES, 16, cycles spent in DRAIN after stop before DONE (0 allowed)

Ports:
clk  input  1  free-running simulation clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin run; sampled in IDLE or DONE
stop  input  1  test-complete request; sampled in RUN
activity  input  NUM_CH  per-channel activity strobe (e.g. valid&ready)
ch_en  input  NUM_CH  per-channel monitor enable
state  output  2  0=IDLE 1=RUN 2=DRAIN 3=DONE
cycle_cnt  output  CNT_W  cycles elapsed since entering RUN
stall_ch  output  NUM_CH  sticky per-channel stall flags
timeout  output  1  sticky global timeout flag
finish_req  output  1  high while in DONE
pass  output  1  valid while finish_req=1

Behaviour:
- Reset (async assert, sync release): state=IDLE; cycle_cnt=0; stall_ch=0; timeout=0; finish_req=0; pass=0; all idle and drain counters=0.
- All outputs are registered. A transition decided in cycle N is visible in cycle N+1.
- IDLE: all counters are held at 0. If start=1, go to RUN. Entry into RUN clears stall_ch and timeout.
- RUN:
  - cycle_cnt increments by 1 every cycle and saturates at all-ones.
  - Per channel i: the idle counter clears when activity[i]=1 or ch_en[i]=0; otherwise it increments.
  - When the idle counter reaches IDLE_LIMIT, stall_ch[i] is set to 1 and stays set until the next RUN entry. The idle counter then holds.
- RUN exit priority, evaluated each cycle, highest first:
  1. Timeout: cycle_cnt==MAX_CYCLES-1 this cycle → timeout=1, go to DONE.
  2. Stall: any stall bit newly set this cycle → go to DONE.
  3. Stop: stop=1 → go to DRAIN; or go straight to DONE if DRAIN_CYCLES=0.
  4. Otherwise stay in RUN.
- DRAIN:
  - cycle_cnt keeps counting.
  - Idle monitoring continues, but a new stall only sets its flag; it does not cause an early exit.
  - The drain counter counts 0..DRAIN_CYCLES-1, then the block goes to DONE.
  - The timeout check still applies: reaching MAX_CYCLES-1 sets timeout=1 and goes to DONE immediately.
- DONE:
  - finish_req=1.
  - pass = (timeout==0) && (stall_ch==0).
  - cycle_cnt freezes.
  - start=1 → RUN: cycle_cnt=0, flags cleared, finish_req and pass drop in the same transition.
- Ignored inputs: start is ignored in RUN and DRAIN. stop is ignored outside RUN.
- Simultaneous events: timeout beats stall, and stall beats stop. Stop and start asserted together in DONE → restart.
- rst_n asserted in any state forces reset values immediately, with no clock edge required.
- Channels with ch_en=0 never stall. Deasserting ch_en mid-run does not clear a stall bit that is already set.

Test Plan:
- Bench parameters: MAX_CYCLES=100, IDLE_LIMIT=10, DRAIN_CYCLES=4, NUM_CH=2, ch_en=2'b11.
- Clean run: start; toggle activity every cycle; stop at cycle_cnt=20 → state=DRAIN for 4 cycles, then DONE. finish_req=1, pass=1, cycle_cnt=25, stall_ch=0.
- Timeout: start; keep activity busy; never assert stop → DONE when cycle_cnt=99. timeout=1, pass=0.
- Stall: start; activity=2'b01 constantly → stall_ch=2'b10 in the cycle after idle count 10, then DONE. pass=0, timeout=0.
- Priority: arrange for stop, a new stall and cycle_cnt=99 to land in the same cycle → DONE with timeout=1 and stall_ch set, and no DRAIN visited.
- Restart and reset: pulse start in DONE → RUN with cycle_cnt=0 and flags clear. Then drop rst_n mid-RUN between clock edges → outputs reach reset values before the next edge.
- Disabled channel: ch_en=2'b01, activity=2'b01 for 50 cycles, then stop → stall_ch=0, pass=1.
